if_id_queue: RTL and testbench
==============================

// Module: if_id_queue
// PURPOSE
//  Instruction queue between the fetch stage and the decode stage. Captures each
//  fetched {pc, pc_plus4, inst} triple into a small FIFO and presents the head
//  entry to ID with valid/ready handshaking. Back-pressures fetch through
//  if_hold (drives IF is_hold). Discards all queued entries on a taken branch.
// PARAMETERS
//  InstAddrWidth  32  width of pc / pc_plus4 fields
//  InstWidth      32  width of instruction word from instruction ROM
//  Depth          2   number of entries; power of two, >= 2
// PORTS
//  clk            in   1              clock; all state updates on posedge
//  rst            in   1              asynchronous reset, active-low (rst==0 resets)
//  if_valid       in   1              fetch output valid (IF ce)
//  if_pc          in   InstAddrWidth  pc of fetched instruction
//  if_pc_plus4    in   InstAddrWidth  pc+4 of fetched instruction
//  if_inst        in   InstWidth      instruction word from ROM
//  if_hold        out  1              1 = queue full, IF must hold pc
//  flush          in   1              taken branch resolved; discard queue
//  id_ready       in   1              ID accepts head entry this cycle
//  id_valid       out  1              head entry valid
//  id_pc          out  InstAddrWidth  head pc
//  id_pc_plus4    out  InstAddrWidth  head pc+4
//  id_inst        out  InstWidth      head instruction
//  count          out  log2(Depth)+1  occupied entries, 0..Depth
// BEHAVIOUR
//  - Reset (rst==0, async): wr_ptr=rd_ptr=0, count=0. Outputs: id_valid=0,
//    id_pc=0, id_pc_plus4=0, id_inst=0 (NOP), if_hold=0. Storage is not cleared.
//  - push = if_valid & ~full & ~flush; pop = id_valid & id_ready & ~flush.
//  - full = (count==Depth); empty = (count==0). if_hold = full, combinational
//    from registered count only; no dependence on id_ready (no comb path IF<->ID).
//  - Push: entry written at wr_ptr on posedge, wr_ptr += 1 mod Depth.
//  - Pop: rd_ptr += 1 mod Depth on posedge.
//  - Simultaneous push and pop (not full): count unchanged, both pointers advance.
//  - Full and id_ready=1: pop only; the held IF triple is pushed on a later cycle.
//  - Empty: id_valid=0; id_pc/id_pc_plus4/id_inst forced to 0 (NOP bubble);
//    id_ready ignored (no underflow).
//  - if_valid=1 while full: ignored, no overflow; IF is expected to re-present it.
//  - Latency: entry pushed at edge N is visible on id_* after edge N (one cycle)
//    if the queue was empty; otherwise after all older entries pop.
//  - flush=1: at posedge count=0, wr_ptr=rd_ptr=0; same-cycle push and pop are
//    suppressed. flush has priority over all other events. Next cycle id_valid=0,
//    if_hold=0.
//  - Ordering: strict FIFO; pointers wrap at Depth without gaps.
//  - count, id_valid, if_hold are mutually consistent every cycle.
//  - Reset asserted mid-operation: immediate return to reset state, independent of clk.
// TESTING
//  1 Reset: rst=0 then 1 -> id_valid=0, id_inst=0, count=0, if_hold=0.
//  2 Fill: id_ready=0, push pc=0x00,0x04 -> count=2, if_hold=1; 3rd push
//    pc=0x08 ignored; id_pc=0x00 held.
//  3 Streaming: if_valid=1, id_ready=1 for 8 cycles, pc 0x00..0x1C -> id_pc
//    sequence 0x00..0x1C one cycle behind, count stays 1, no drops or duplicates.
//  4 Full + pop: queue holds 0x00,0x04, id_ready=1 -> next cycle count=1,
//    id_pc=0x04, if_hold=0; following push 0x08 lands behind 0x04.
//  5 Flush: queue holds 2 entries, flush=1 with if_valid=1 pc=0x08 -> next
//    cycle count=0, id_valid=0, 0x08 not captured; push 0x40 -> id_pc=0x40.
//  6 Async reset: with count=2, drop rst between edges -> count=0, id_valid=0
//    before the next posedge.

Source files
------------

// File: rtl/if_id_queue.sv
// IF->ID instruction queue: buffers fetched {pc, pc_plus4, inst} triples and
// hands the oldest one to decode, holding fetch when full and emptying on flush.
module if_id_queue #(
    parameter int InstAddrWidth = 32,
    parameter int InstWidth     = 32,
    parameter int Depth         = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_valid,
    input  logic [InstAddrWidth-1:0] if_pc,
    input  logic [InstAddrWidth-1:0] if_pc_plus4,
    input  logic [InstWidth-1:0]     if_inst,
    output logic                     if_hold,
    input  logic                     flush,
    input  logic                     id_ready,
    output logic                     id_valid,
    output logic [InstAddrWidth-1:0] id_pc,
    output logic [InstAddrWidth-1:0] id_pc_plus4,
    output logic [InstWidth-1:0]     id_inst,
    output logic [$clog2(Depth):0]   count
);

    localparam int PtrW   = $clog2(Depth);
    localparam int CntW   = PtrW + 1;
    localparam int EntryW = 2 * InstAddrWidth + InstWidth;
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [EntryW-1:0] mem_q [Depth];
    logic [EntryW-1:0] head_s;
    logic              full_s, empty_s, push_s, pop_s;

    // Handshake decode and next-state for pointers and occupancy; flush wins.
    always_comb begin
        full_s   = (count_q == DepthCnt);
        empty_s  = (count_q == {CntW{1'b0}});
        push_s   = if_valid & ~full_s & ~flush;
        pop_s    = ~empty_s & id_ready & ~flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {PtrW{1'b0}};
            rd_ptr_d = {PtrW{1'b0}};
            count_d  = {CntW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= {PtrW{1'b0}};
            rd_ptr_q <= {PtrW{1'b0}};
            count_q  <= {CntW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is deliberately left unreset; empty reads are masked below.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {if_pc, if_pc_plus4, if_inst};
        end
    end

    // Head presentation: a NOP bubble of zeros whenever nothing is queued.
    always_comb begin
        head_s   = mem_q[rd_ptr_q];
        if_hold  = full_s;
        id_valid = ~empty_s;
        count    = count_q;
        if (empty_s) begin
            id_pc       = {InstAddrWidth{1'b0}};
            id_pc_plus4 = {InstAddrWidth{1'b0}};
            id_inst     = {InstWidth{1'b0}};
        end else begin
            id_pc       = head_s[EntryW-1 -: InstAddrWidth];
            id_pc_plus4 = head_s[InstWidth +: InstAddrWidth];
            id_inst     = head_s[InstWidth-1:0];
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: a queue of expected entries is fed by the
// stimulus side and drained by a monitor that checks every decode-side cycle.
module tb_if_id_queue;

    localparam int Depth = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = 32'd0;
    logic [31:0] if_pc_plus4 = 32'd0;
    logic [31:0] if_inst = 32'd0;
    logic        flush = 1'b0;
    logic        id_ready = 1'b0;
    logic        if_hold;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_inst;
    logic [1:0]  count;

    ent_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;
    int   pre_size = 0;

    if_id_queue #(.InstAddrWidth(32), .InstWidth(32), .Depth(Depth)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_inst(if_inst),
        .if_hold(if_hold), .flush(flush), .id_ready(id_ready),
        .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_inst(id_inst),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compares presented state with the model, retires handshaken heads.
    always begin
        @(negedge clk);
        #1;
        if (mon_en) begin
            pre_size = exp_q.size();
            chk("count", 32'(count), 32'(pre_size));
            chk("id_valid", 32'(id_valid), 32'(pre_size > 0));
            chk("if_hold", 32'(if_hold), 32'(pre_size == Depth));
            if (pre_size > 0) begin
                chk("id_pc", id_pc, exp_q[0].pc);
                chk("id_pc_plus4", id_pc_plus4, exp_q[0].pc4);
                chk("id_inst", id_inst, exp_q[0].inst);
                if (id_ready && !flush) void'(exp_q.pop_front());
            end else begin
                chk("bubble_pc", id_pc, 32'd0);
                chk("bubble_inst", id_inst, 32'd0);
            end
        end
    end

    // One clock of stimulus; records accepted pushes / flushes in the model.
    task automatic cycle(input bit v, input logic [31:0] pc, input bit rdy, input bit fl);
        logic [31:0] inst;
        inst = $urandom;
        @(negedge clk);
        if_valid    = v;
        if_pc       = pc;
        if_pc_plus4 = pc + 32'd4;
        if_inst     = inst;
        id_ready    = rdy;
        flush       = fl;
        #2;
        if (mon_en) begin
            if (fl) exp_q.delete();
            else if (v && pre_size < Depth) exp_q.push_back('{pc, pc + 32'd4, inst});
        end
    endtask

    initial begin
        // Reset state, then release.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_id_valid", 32'(id_valid), 32'd0);
        chk("rel_id_inst", id_inst, 32'd0);
        chk("rel_count", 32'(count), 32'd0);
        chk("rel_if_hold", 32'(if_hold), 32'd0);
        mon_en = 1'b1;

        // Fill, overflow attempt, then pop from full and push behind.
        cycle(1'b1, 32'h00, 1'b0, 1'b0);
        cycle(1'b1, 32'h04, 1'b0, 1'b0);
        cycle(1'b1, 32'h08, 1'b0, 1'b0);
        cycle(1'b0, 32'h00, 1'b0, 1'b0);
        cycle(1'b0, 32'h00, 1'b1, 1'b0);
        cycle(1'b1, 32'h08, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 32'h00, 1'b1, 1'b0);

        // Streaming with ID always ready.
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'(i * 4), 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 32'h00, 1'b1, 1'b0);

        // Flush with a concurrent fetch, then a fresh push.
        cycle(1'b1, 32'h00, 1'b0, 1'b0);
        cycle(1'b1, 32'h04, 1'b0, 1'b0);
        cycle(1'b1, 32'h08, 1'b0, 1'b1);
        cycle(1'b1, 32'h40, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 32'h00, 1'b1, 1'b0);

        // Asynchronous reset between clock edges with the queue full.
        cycle(1'b1, 32'h00, 1'b0, 1'b0);
        cycle(1'b1, 32'h04, 1'b0, 1'b0);
        cycle(1'b0, 32'h00, 1'b0, 1'b0);
        @(negedge clk);
        mon_en = 1'b0;
        if_valid = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_id_valid", 32'(id_valid), 32'd0);
        chk("arst_if_hold", 32'(if_hold), 32'd0);
        chk("arst_id_inst", id_inst, 32'd0);
        exp_q.delete();
        @(negedge clk);
        #3;
        rst = 1'b1;
        mon_en = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15) == 0);
        end
        repeat (3) cycle(1'b0, 32'h00, 1'b1, 1'b0);

        @(negedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
